// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: access codes, FSM/fault
// encodings and the request classification helpers.
package mem_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] LB      = 3'b001;
  localparam logic [2:0] LH      = 3'b010;
  localparam logic [2:0] LW      = 3'b011;
  localparam logic [2:0] LBU     = 3'b100;
  localparam logic [2:0] LHU     = 3'b101;
  localparam logic [2:0] SB      = 3'b001;
  localparam logic [2:0] SH      = 3'b010;
  localparam logic [2:0] SW      = 3'b011;

  localparam int TIMER_W = 10;

  typedef enum logic [1:0] {IDLE, BUS, RESP, FAULT} state_t;
  typedef enum logic [1:0] {NONE, MISALIGN, ILLEGAL, TIMEOUT} fault_t;

  // Only called on legal requests, so store codes share the load encodings.
  function automatic logic ldst_is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op)
      LH, LHU: return addr_lo[0];
      LW:      return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ldst_is_legal(input logic rd, input logic wr, input logic [2:0] op);
    if (rd && wr) return 1'b0;
    if (rd)       return (op >= LB) && (op <= LHU);
    return (op >= SB) && (op <= SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension
// for loads. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        st_we_i,
  input  logic [2:0]  st_op_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  ld_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // NOTE: every output of a combinational block is given a default first so
  // that no path leaves it unassigned, which would infer a latch.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = '0;
    if (st_we_i) begin
      wdata_o = st_data_i;
      case (st_op_i)
        SB: begin
          be_o    = 4'b0001 << st_lo_i;
          wdata_o = {4{st_data_i[7:0]}};
        end
        SH: begin
          be_o    = 4'b0011 << st_lo_i;
          wdata_o = {2{st_data_i[15:0]}};
        end
        default: be_o = 4'b1111;
      endcase
    end
  end

  assign byte_sh = rdata_i >> {ld_lo_i, 3'b000};
  assign half_sh = rdata_i >> {ld_lo_i[1], 4'b0000};

  always_comb begin
    ldata_o = '0;
    case (ld_op_i)
      LB:      ldata_o = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LBU:     ldata_o = {24'h0, byte_sh[7:0]};
      LH:      ldata_o = {{16{half_sh[15]}}, half_sh[15:0]};
      LHU:     ldata_o = {16'h0, half_sh[15:0]};
      LW:      ldata_o = rdata_i;
      default: ldata_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory responder: runs one load/store over a req/ack word bus with wait
// states and a timeout, stalling the core until the access completes or faults.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadEn,
  input  logic        MemWriteEn,
  input  logic [2:0]  MemoryOperation,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Stall,
  output logic        DoneValid,
  output logic [31:0] LoadData,
  output logic        Fault,
  output logic [1:0]  FaultCause,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  output logic [3:0]  MemBe,
  input  logic [31:0] MemRdata,
  input  logic        MemAck
);

  state_t              state_q, state_d;
  fault_t              cause_q, cause_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          lo_q, lo_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         ldata_q, ldata_d;

  logic                req;
  logic                in_bus;
  logic [3:0]          st_be;
  logic [31:0]         st_wdata;
  logic [31:0]         ld_data;

  assign req    = MemReadEn | MemWriteEn;
  assign in_bus = (state_q == BUS);

  mem_lane_align u_align (
    .st_we_i   (MemWriteEn),
    .st_op_i   (MemoryOperation),
    .st_lo_i   (Addr[1:0]),
    .st_data_i (StoreData),
    .be_o      (st_be),
    .wdata_o   (st_wdata),
    .ld_op_i   (op_q),
    .ld_lo_i   (lo_q),
    .rdata_i   (MemRdata),
    .ldata_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    timer_d = timer_q;
    op_d    = op_q;
    lo_d    = lo_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (req) begin
          if (!ldst_is_legal(MemReadEn, MemWriteEn, MemoryOperation)) begin
            cause_d = ILLEGAL;
            state_d = FAULT;
          end else if (ldst_is_misaligned(MemoryOperation, Addr[1:0])) begin
            cause_d = MISALIGN;
            state_d = FAULT;
          end else begin
            op_d    = MemoryOperation;
            lo_d    = Addr[1:0];
            we_d    = MemWriteEn;
            addr_d  = {Addr[31:2], 2'b00};
            be_d    = st_be;
            wdata_d = st_wdata;
            cause_d = NONE;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // An acknowledge in the last allowed cycle still completes normally.
        if (MemAck) begin
          ldata_d = we_q ? '0 : ld_data;
          state_d = RESP;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          cause_d = TIMEOUT;
          state_d = FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= NONE;
      timer_q <= '0;
      op_q    <= OP_NONE;
      lo_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      timer_q <= timer_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
    end
  end

  // Bus fields are only driven while a transaction is outstanding.
  assign MemReq     = in_bus;
  assign MemWe      = in_bus & we_q;
  assign MemAddr    = in_bus ? addr_q  : '0;
  assign MemBe      = in_bus ? be_q    : '0;
  assign MemWdata   = in_bus ? wdata_q : '0;

  assign Stall      = ((state_q == IDLE) && req) || in_bus;
  assign DoneValid  = (state_q == RESP) || (state_q == FAULT);
  assign Fault      = (state_q == FAULT);
  assign FaultCause = (state_q == FAULT) ? cause_q : NONE;
  assign LoadData   = (state_q == RESP) ? ldata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level reference model
// predicts every output each cycle; directed cases pin key literal values.
module tb_mem_access_unit;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadEn, MemWriteEn;
  logic [2:0]  MemoryOperation;
  logic [31:0] Addr, StoreData;
  logic        Stall, DoneValid, Fault;
  logic [31:0] LoadData;
  logic [1:0]  FaultCause;
  logic        MemReq, MemWe;
  logic [31:0] MemAddr, MemWdata;
  logic [3:0]  MemBe;
  logic [31:0] MemRdata;
  logic        MemAck;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .MemReadEn       (MemReadEn),
    .MemWriteEn      (MemWriteEn),
    .MemoryOperation (MemoryOperation),
    .Addr            (Addr),
    .StoreData       (StoreData),
    .Stall           (Stall),
    .DoneValid       (DoneValid),
    .LoadData        (LoadData),
    .Fault           (Fault),
    .FaultCause      (FaultCause),
    .MemReq          (MemReq),
    .MemWe           (MemWe),
    .MemAddr         (MemAddr),
    .MemWdata        (MemWdata),
    .MemBe           (MemBe),
    .MemRdata        (MemRdata),
    .MemAck          (MemAck)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs for the current cycle, checked by the compare process.
  logic        exp_valid = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_done, exp_fault, exp_chk_wd;
  logic [1:0]  exp_cause;
  logic [31:0] exp_addr, exp_wd, exp_ld;
  logic [3:0]  exp_be;

  always @(negedge clk) begin
    if (exp_valid) begin
      check("Stall",      32'(Stall),      32'(exp_stall));
      check("MemReq",     32'(MemReq),     32'(exp_req));
      check("DoneValid",  32'(DoneValid),  32'(exp_done));
      check("Fault",      32'(Fault),      32'(exp_fault));
      check("FaultCause", 32'(FaultCause), 32'(exp_cause));
      check("LoadData",   LoadData,        exp_ld);
      if (exp_req) begin
        check("MemWe",   32'(MemWe),   32'(exp_we));
        check("MemAddr", MemAddr,      exp_addr);
        check("MemBe",   32'(MemBe),   32'(exp_be));
        if (exp_chk_wd) check("MemWdata", MemWdata, exp_wd);
      end
    end
  end

  // ---------------- reference model (access-level arithmetic) ----------------
  function automatic logic m_illegal(input logic rd, input logic wr, input logic [2:0] op);
    if (rd && wr) return 1'b1;
    if (rd) return !(op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
    return !(op inside {3'd1, 3'd2, 3'd3});
  endfunction

  function automatic int m_size(input logic [2:0] op);
    case (op)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      3'd3:       return 4;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input int a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a);
    case (op)
      3'd1: begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd4: v = v % 256;
      3'd2: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd5: v = v % 65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  // Results of the most recent transaction, for literal pins.
  int          t_done_k, t_req_cnt;
  logic [31:0] t_ld, t_wd;
  logic [1:0]  t_cause;
  logic        t_fault;
  logic [3:0]  t_be;

  task automatic idle_cycle();
    @(posedge clk); #1;
    MemReadEn = 1'b0; MemWriteEn = 1'b0;
    MemoryOperation = 3'($urandom); Addr = $urandom; StoreData = $urandom;
    MemAck = 1'b0; MemRdata = $urandom;
    exp_valid = 1'b1; exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0;
    exp_fault = 1'b0; exp_cause = 2'd0; exp_ld = '0;
    @(negedge clk);
  endtask

  // ack_n: MemAck at cycle 1+ack_n; negative means it never comes.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [31:0] rdata, input int ack_n);
    logic pre_fault, timed_out;
    logic [1:0] pre_cause;
    int sz, a, last;
    sz = m_size(op);
    a  = int'(addr % 4);
    pre_fault = 1'b0; pre_cause = 2'd0;
    if (m_illegal(rd, wr, op)) begin
      pre_fault = 1'b1; pre_cause = 2'd2;
    end else if ((addr % sz) != 0) begin
      pre_fault = 1'b1; pre_cause = 2'd1;
    end
    timed_out = !(ack_n >= 0 && ack_n <= TO - 1);
    if (pre_fault)      last = 1;
    else if (timed_out) last = 1 + TO;
    else                last = 2 + ack_n;
    t_done_k = -1; t_req_cnt = 0; t_ld = '0; t_cause = '0; t_fault = 1'b0;
    t_be = '0; t_wd = '0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        MemReadEn = rd; MemWriteEn = wr; MemoryOperation = op;
        Addr = addr; StoreData = sd;
      end else begin
        MemReadEn = 1'($urandom); MemWriteEn = 1'($urandom);
        MemoryOperation = 3'($urandom); Addr = $urandom; StoreData = $urandom;
      end
      MemAck   = (!pre_fault && !timed_out && k == 1 + ack_n);
      MemRdata = MemAck ? rdata : $urandom;
      exp_valid = 1'b1;
      exp_stall = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_fault = 1'b0;
      exp_cause = 2'd0; exp_ld = '0; exp_we = wr; exp_chk_wd = wr;
      exp_addr  = addr - 32'(a);
      exp_be    = 4'hF;
      if (wr && sz == 1) exp_be = 4'(1 << a);
      if (wr && sz == 2) exp_be = 4'(3 << a);
      exp_wd = sd;
      if (sz == 1) exp_wd = (sd % 256) * 32'h0101_0101;
      if (sz == 2) exp_wd = (sd % 65536) * 32'h0001_0001;
      if (k == 0) begin
        exp_stall = 1'b1;
      end else if (k < last) begin
        exp_stall = 1'b1; exp_req = 1'b1;
      end else begin
        exp_done = 1'b1;
        if (pre_fault) begin
          exp_fault = 1'b1; exp_cause = pre_cause;
        end else if (timed_out) begin
          exp_fault = 1'b1; exp_cause = 2'd3;
        end else begin
          exp_ld = wr ? 32'h0 : m_load(op, a, rdata);
        end
      end
      @(negedge clk);
      if (MemReq) t_req_cnt++;
      if (k == 1) begin t_be = MemBe; t_wd = MemWdata; end
      if (DoneValid && t_done_k < 0) begin
        t_done_k = k; t_ld = LoadData; t_cause = FaultCause; t_fault = Fault;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_Stall"},     32'(Stall),      32'h0);
    check({tag, "_DoneValid"}, 32'(DoneValid),  32'h0);
    check({tag, "_LoadData"},  LoadData,        32'h0);
    check({tag, "_Fault"},     32'(Fault),      32'h0);
    check({tag, "_Cause"},     32'(FaultCause), 32'h0);
    check({tag, "_MemReq"},    32'(MemReq),     32'h0);
    check({tag, "_MemWe"},     32'(MemWe),      32'h0);
    check({tag, "_MemAddr"},   MemAddr,         32'h0);
    check({tag, "_MemWdata"},  MemWdata,        32'h0);
    check({tag, "_MemBe"},     32'(MemBe),      32'h0);
  endtask

  initial begin
    rst = 1'b1;
    MemReadEn = 1'b0; MemWriteEn = 1'b0; MemoryOperation = 3'd0;
    Addr = '0; StoreData = '0; MemRdata = '0; MemAck = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    idle_cycle();

    // SW with immediate acknowledge.
    run_txn(1'b0, 1'b1, 3'd3, 32'h100, 32'hDEAD_BEEF, 32'h0, 0);
    check("sw_done_cycle", 32'(t_done_k), 32'd2);
    check("sw_be",         32'(t_be),     32'hF);
    check("sw_wdata",      t_wd,          32'hDEAD_BEEF);

    // LB / LBU at lane 3 with three wait states, back-to-back.
    run_txn(1'b1, 1'b0, 3'd1, 32'h103, 32'h0, 32'h80FF_1234, 3);
    check("lb_done_cycle", 32'(t_done_k), 32'd5);
    check("lb_data",       t_ld,          32'hFFFF_FF80);
    run_txn(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_1234, 3);
    check("lbu_data",      t_ld,          32'h0000_0080);

    // SH / LH at the upper half.
    run_txn(1'b0, 1'b1, 3'd2, 32'h102, 32'h1234_ABCD, 32'h0, 1);
    check("sh_be",    32'(t_be), 32'hC);
    check("sh_wdata", t_wd,      32'hABCD_ABCD);
    run_txn(1'b1, 1'b0, 3'd2, 32'h102, 32'h0, 32'h8001_0000, 2);
    check("lh_data",  t_ld,      32'hFFFF_8001);

    // Misaligned LW and an illegal request.
    idle_cycle();
    run_txn(1'b1, 1'b0, 3'd3, 32'h101, 32'h0, 32'h0, 0);
    check("mis_done_cycle", 32'(t_done_k),  32'd1);
    check("mis_cause",      32'(t_cause),   32'd1);
    check("mis_req_cycles", 32'(t_req_cnt), 32'd0);
    run_txn(1'b1, 1'b1, 3'd1, 32'h100, 32'h0, 32'h0, 0);
    check("ill_cause",      32'(t_cause),   32'd2);

    // Timeout, then acknowledge in the very last allowed cycle.
    run_txn(1'b1, 1'b0, 3'd3, 32'h200, 32'h0, 32'h0, -1);
    check("to_req_cycles",  32'(t_req_cnt), 32'd64);
    check("to_cause",       32'(t_cause),   32'd3);
    check("to_fault",       32'(t_fault),   32'd1);
    run_txn(1'b1, 1'b0, 3'd3, 32'h200, 32'h0, 32'h1357_9BDF, TO - 1);
    check("lastack_fault",  32'(t_fault),   32'd0);
    check("lastack_data",   t_ld,           32'h1357_9BDF);
    check("lastack_cycle",  32'(t_done_k),  32'd65);

    // Reset on the second bus cycle, then a late acknowledge.
    exp_valid = 1'b0;
    @(posedge clk); #1;
    MemReadEn = 1'b1; MemWriteEn = 1'b0; MemoryOperation = 3'd3; Addr = 32'h300;
    @(posedge clk); #1;
    MemReadEn = 1'b0;
    @(negedge clk);
    check("rst_bus1_req", 32'(MemReq), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst_bus2_req", 32'(MemReq), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_rst");
    @(posedge clk); #1 MemAck = 1'b1; MemRdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_all_zero("late_ack");
    @(posedge clk); #1 MemAck = 1'b0;
    @(negedge clk);
    check_all_zero("post_late_ack");
    run_txn(1'b0, 1'b1, 3'd3, 32'h400, 32'hCAFE_F00D, 32'h0, 2);
    check("post_rst_sw_done", 32'(t_done_k), 32'd4);
    check("post_rst_sw_fault", 32'(t_fault), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      int r, r2, ack_n;
      logic rd, wr;
      logic [2:0] op;
      logic [31:0] addr;
      r = $urandom_range(0, 19);
      rd = 1'b0; wr = 1'b0;
      op = 3'($urandom);
      if (r < 9) begin
        rd = 1'b1; op = 3'($urandom_range(1, 5));
      end else if (r < 17) begin
        wr = 1'b1; op = 3'($urandom_range(1, 3));
      end else if (r == 17) begin
        rd = 1'b1; wr = 1'b1;
      end else if (r == 18) begin
        rd = 1'b1; op = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(6, 7));
      end else begin
        wr = 1'b1; op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(4, 7));
      end
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % 32'(m_size(op)));
      r2 = $urandom_range(0, 39);
      if (r2 < 36)       ack_n = $urandom_range(0, 6);
      else if (r2 == 36) ack_n = TO - 2;
      else if (r2 == 37) ack_n = TO - 1;
      else if (r2 == 38) ack_n = -1;
      else               ack_n = TO;
      run_txn(rd, wr, op, addr, $urandom, $urandom, ack_n);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end

    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory responder for the single-cycle core: consumes the decoded load/store controls (MemReadEn, MemWriteEn, MemoryOperation) plus the ALU address and rs2 data.
- Executes each access over a word-wide request/acknowledge memory bus with variable wait states.
- Performs byte-lane steering for stores, and lane extraction with sign/zero extension for loads.
- Stalls the core until the access completes, faults or times out.

Parameters:
- TIMEOUT_CYCLES, 64: bus cycles waited for MemAck before a timeout fault; valid range 1..1023.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- MemReadEn  in  1  load request from decoder
- MemWriteEn  in  1  store request from decoder
- MemoryOperation  in  3  access code from mem_pkg
- Addr  in  32  byte address (ALU result)
- StoreData  in  32  rs2 value
- Stall  out  1  core must hold PC/instruction
- DoneValid  out  1  one-cycle completion pulse
- LoadData  out  32  extended load result, valid with DoneValid
- Fault  out  1  qualifies DoneValid: access failed
- FaultCause  out  2  NONE / MISALIGN / ILLEGAL / TIMEOUT
- MemReq  out  1  bus request, held until MemAck
- MemWe  out  1  1 = write
- MemAddr  out  32  word address, bits[1:0] = 0
- MemWdata  out  32  lane-replicated store data
- MemBe  out  4  byte enables
- MemRdata  in  32  read word, valid with MemAck
- MemAck  in  1  completes the bus transaction

Behaviour:
- Reset values: all outputs 0; state IDLE; timer 0.
- Access codes: load 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU. Store (MemWriteEn) 001 SB, 010 SH, 011 SW. 000 = none.
- Request: a request is present when MemReadEn or MemWriteEn is high.
- IDLE:
  - Stall = request present.
  - Illegal request (both enables set, or undefined code) -> FAULT, cause ILLEGAL.
  - Misaligned request (H with Addr[0] = 1, W with Addr[1:0] != 0) -> FAULT, cause MISALIGN; no bus activity.
  - Otherwise latch op, Addr[1:0], MemAddr, MemWe, MemBe, MemWdata -> BUS.
- BUS:
  - MemReq = 1 with stable MemAddr/MemWe/MemBe/MemWdata; Stall = 1; timer increments each cycle.
  - MemAck -> capture formatted MemRdata -> RESP.
  - Timer reaches TIMEOUT_CYCLES - 1 without MemAck -> FAULT, cause TIMEOUT.
  - MemAck and timeout in the same cycle: MemAck wins.
- RESP: DoneValid = 1, LoadData valid (0 for stores), Stall = 0, MemReq = 0 -> IDLE.
- FAULT: DoneValid = 1, Fault = 1, LoadData = 0, Stall = 0 -> IDLE.
- Latency: request seen at cycle 0; MemReq at cycle 1. MemAck at cycle 1+N gives DoneValid at cycle 2+N. Fault paths through IDLE complete at cycle 1.
- Back-to-back: a new request present in IDLE the cycle after DoneValid is accepted immediately.
- Store lanes:
  - SB: MemBe = 0001 << a, MemWdata = {4{StoreData[7:0]}}.
  - SH: MemBe = 0011 << a, MemWdata = {2{StoreData[15:0]}}.
  - SW: MemBe = 1111, MemWdata = StoreData.
- Load: MemBe = 1111. Extract byte/half at lane a; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Reset mid-operation: the next cycle drops MemReq and returns to IDLE. A late MemAck in IDLE is ignored; no DoneValid is produced.
- Inputs are sampled only in IDLE; changes during BUS are ignored.

Decomposition:
- mem_pkg holds:
  - access code localparams (LB..LHU, SB..SW);
  - enum state_t {IDLE, BUS, RESP, FAULT};
  - enum fault_t {NONE, MISALIGN, ILLEGAL, TIMEOUT};
  - the function ldst_is_misaligned.
- Sub-module mem_lane_align (combinational) provides store steering (MemBe, MemWdata) and load extraction/extension. The FSM, timer and latches remain in mem_access_unit.

Test Plan:
- SW, Addr 0x100, StoreData 0xDEADBEEF, MemAck at cycle 1 -> at cycle 1: MemReq = 1, MemAddr 0x100, MemBe 1111, MemWdata 0xDEADBEEF; cycle 2: DoneValid = 1, Stall = 0.
- LB / LBU, Addr 0x103, MemRdata 0x80FF1234, MemAck after 3 waits -> LoadData 0xFFFFFF80 / 0x00000080, DoneValid at cycle 5, Stall high cycles 0-4.
- SH, Addr 0x102, StoreData 0x1234ABCD -> MemBe 1100, MemWdata 0xABCDABCD. LH at the same address with MemRdata 0x8001_0000 -> LoadData 0xFFFF8001.
- LW, Addr 0x101 -> MemReq never asserted; cycle 1: DoneValid = 1, Fault = 1, FaultCause MISALIGN, LoadData 0.
- LW, Addr 0x200, MemAck never arrives, TIMEOUT_CYCLES 64 -> MemReq high for 64 cycles, then Fault with cause TIMEOUT and MemReq = 0. A second run with MemAck in the final cycle -> normal RESP.
- rst asserted on the 2nd BUS cycle, MemAck pulsed 2 cycles later -> MemReq = 0 after rst, all outputs 0, no DoneValid; the next SW completes normally.
